// File: rtl/river_pkg.sv
// Shared types and constants for the river collision checker.
package river_pkg;
  localparam int PIX_CNT_W = 8;
  localparam int LIVES_W   = 2;

  localparam int DEFAULT_CRASH_THRESHOLD = 8;
  localparam int DEFAULT_FOAM_THRESHOLD  = 4;
  localparam int DEFAULT_LIVES           = 3;
  localparam int DEFAULT_GRACE_FRAMES    = 60;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    GRACE  = 2'd1,
    OVER   = 2'd2
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter
  import river_pkg::*;
#(
  parameter int W = PIX_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/river_collision_checker.sv
// Frame-level boat/bank and boat/foam collision decision, lives and grace window.
// Foam detection is built only when RIVER_COLLISION_FOAM_EN is defined.
module river_collision_checker
  import river_pkg::*;
#(
  parameter int CRASH_THRESHOLD = DEFAULT_CRASH_THRESHOLD,
  parameter int FOAM_THRESHOLD  = DEFAULT_FOAM_THRESHOLD,
  parameter int LIVES           = DEFAULT_LIVES,
  parameter int GRACE_FRAMES    = DEFAULT_GRACE_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic               player_on,
  input  logic               river_on,
  input  logic               foam_on,
  input  logic               update_signal,
  input  logic               restart,
  output logic               crash,
  output logic               foam_hit,
  output logic [LIVES_W-1:0] lives,
  output logic               invuln,
  output logic               game_over
);
  localparam logic [PIX_CNT_W-1:0] CRASH_TH   = PIX_CNT_W'(CRASH_THRESHOLD);
  localparam logic [PIX_CNT_W-1:0] GRACE_LOAD = PIX_CNT_W'(GRACE_FRAMES);
  localparam logic [LIVES_W-1:0]   LIVES_LOAD = LIVES_W'(LIVES);

  state_t               state_reg, state_next;
  logic [LIVES_W-1:0]   lives_reg, lives_next;
  logic [PIX_CNT_W-1:0] grace_cnt_reg, grace_cnt_next;
  logic                 crash_reg, crash_next;
  logic                 video_on_d, player_on_d;
  logic                 boat_px;
  logic                 cnt_clr;
  logic [PIX_CNT_W-1:0] bank_cnt;

  // Delay the coordinate-aligned flags to line up with the drawer's ROM lag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      video_on_d  <= 1'b0;
      player_on_d <= 1'b0;
    end else begin
      video_on_d  <= video_on;
      player_on_d <= player_on;
    end
  end

  assign boat_px = video_on_d & player_on_d;
  assign cnt_clr = update_signal | restart | (state_reg != ACTIVE);

  sat_counter #(.W(PIX_CNT_W)) u_bank_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (boat_px & ~river_on),
    .clr   (cnt_clr),
    .count (bank_cnt)
  );

`ifdef RIVER_COLLISION_FOAM_EN
  localparam logic [PIX_CNT_W-1:0] FOAM_TH = PIX_CNT_W'(FOAM_THRESHOLD);
  logic [PIX_CNT_W-1:0] foam_cnt;
  logic                 foam_hit_reg, foam_hit_next;

  sat_counter #(.W(PIX_CNT_W)) u_foam_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (boat_px & foam_on),
    .clr   (cnt_clr),
    .count (foam_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) foam_hit_reg <= 1'b0;
    else        foam_hit_reg <= foam_hit_next;
  end

  assign foam_hit = foam_hit_reg;
`else
  logic unused_foam_on;
  assign unused_foam_on = foam_on;
  assign foam_hit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ACTIVE;
      lives_reg     <= LIVES_LOAD;
      grace_cnt_reg <= '0;
      crash_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lives_reg     <= lives_next;
      grace_cnt_reg <= grace_cnt_next;
      crash_reg     <= crash_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    lives_next     = lives_reg;
    grace_cnt_next = grace_cnt_reg;
    crash_next     = 1'b0;
`ifdef RIVER_COLLISION_FOAM_EN
    foam_hit_next  = 1'b0;
`endif
    if (restart) begin
      state_next     = ACTIVE;
      lives_next     = LIVES_LOAD;
      grace_cnt_next = '0;
    end else if (update_signal) begin
      case (state_reg)
        ACTIVE: begin
          if (bank_cnt >= CRASH_TH) begin
            crash_next = 1'b1;
            lives_next = lives_reg - 1'b1;
            if (lives_reg == LIVES_W'(1)) begin
              state_next = OVER;
            end else begin
              state_next     = GRACE;
              grace_cnt_next = GRACE_LOAD;
            end
          end
`ifdef RIVER_COLLISION_FOAM_EN
          else if (foam_cnt >= FOAM_TH) begin
            foam_hit_next = 1'b1;
          end
`endif
        end
        GRACE: begin
          grace_cnt_next = grace_cnt_reg - 1'b1;
          if (grace_cnt_reg == PIX_CNT_W'(1)) state_next = ACTIVE;
        end
        default: ;
      endcase
    end
  end

  assign crash     = crash_reg;
  assign lives     = lives_reg;
  assign invuln    = (state_reg == GRACE);
  assign game_over = (state_reg == OVER);
endmodule

// File: tb/tb_river_collision_checker.sv
// Directed scoreboard bench for river_collision_checker (default parameters).
module tb_river_collision_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b0, player_on = 1'b0, river_on = 1'b1, foam_on = 1'b0;
  logic       update_signal = 1'b0, restart = 1'b0;
  logic       crash, foam_hit, invuln, game_over;
  logic [1:0] lives;

  int compared = 0;
  int mismatched = 0;

  bit prev_riv = 1'b1;
  bit prev_fm  = 1'b0;

  // Reference model: 0 ACTIVE, 1 GRACE, 2 OVER
  int m_state = 0, m_lives = 3, m_grace = 0, m_bank = 0, m_foam = 0;
  bit foam_en;

  typedef struct {
    string      tag;
    bit         crash;
    bit         foam;
    logic [1:0] lives;
    bit         invuln;
    bit         go;
  } exp_t;
  exp_t sb[$];

  river_collision_checker dut (
    .clk           (clk),
    .reset         (reset),
    .video_on      (video_on),
    .player_on     (player_on),
    .river_on      (river_on),
    .foam_on       (foam_on),
    .update_signal (update_signal),
    .restart       (restart),
    .crash         (crash),
    .foam_hit      (foam_hit),
    .lives         (lives),
    .invuln        (invuln),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // One cycle of stimulus; river/foam carry the previous pixel's value.
  task automatic drive(input bit vid, input bit pl, input bit riv, input bit fm,
                       input bit upd, input bit rs);
    @(negedge clk);
    video_on      = vid;
    player_on     = pl;
    river_on      = prev_riv;
    foam_on       = prev_fm;
    prev_riv      = riv;
    prev_fm       = fm;
    update_signal = upd;
    restart       = rs;
  endtask

  task automatic pix(input bit outside, input bit foam);
    drive(1'b1, 1'b1, ~outside, foam, 1'b0, 1'b0);
    if (m_state == 0) begin
      if (outside && m_bank < 255) m_bank++;
      if (foam && m_foam < 255) m_foam++;
    end
  endtask

  task automatic frame(input int n_out, input int n_foam_in_water);
    for (int i = 0; i < n_out; i++) pix(1'b1, 1'b0);
    for (int i = 0; i < n_foam_in_water; i++) pix(1'b0, 1'b1);
  endtask

  task automatic peek_bank(input string tag, input int exp_v);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk(tag, dut.bank_cnt, 8'(exp_v));
  endtask

  task automatic tick(input string tag, input bit rs);
    exp_t e;
    exp_t got;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e.tag = tag; e.crash = 0; e.foam = 0;
    if (rs) begin
      m_state = 0; m_lives = 3; m_grace = 0;
    end else if (m_state == 0) begin
      if (m_bank >= 8) begin
        e.crash = 1;
        if (m_lives == 1) m_state = 2;
        else begin m_state = 1; m_grace = 60; end
        m_lives--;
      end else if (foam_en && m_foam >= 4) begin
        e.foam = 1;
      end
    end else if (m_state == 1) begin
      m_grace--;
      if (m_grace == 0) m_state = 0;
    end
    m_bank = 0; m_foam = 0;
    e.lives = 2'(m_lives); e.invuln = (m_state == 1); e.go = (m_state == 2);
    sb.push_back(e);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, rs);
    @(posedge clk); #1;
    got = sb.pop_front();
    chk({got.tag, ".crash"},  8'(crash),     8'(got.crash));
    chk({got.tag, ".foam"},   8'(foam_hit),  8'(got.foam));
    chk({got.tag, ".lives"},  8'(lives),     8'(got.lives));
    chk({got.tag, ".invuln"}, 8'(invuln),    8'(got.invuln));
    chk({got.tag, ".over"},   8'(game_over), 8'(got.go));
    $display("tick %s: crash=%0b foam_hit=%0b lives=%0d invuln=%0b game_over=%0b",
             got.tag, crash, foam_hit, lives, invuln, game_over);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk({got.tag, ".crash_width"}, 8'(crash),    8'd0);
    chk({got.tag, ".foam_width"},  8'(foam_hit), 8'd0);
  endtask

  task automatic grace_ticks(input int n);
    for (int i = 0; i < n; i++) tick("grace", 1'b0);
  endtask

  initial begin
`ifdef RIVER_COLLISION_FOAM_EN
    foam_en = 1'b1;
`else
    foam_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset.lives",  8'(lives),     8'd3);
    chk("reset.crash",  8'(crash),     8'd0);
    chk("reset.foam",   8'(foam_hit),  8'd0);
    chk("reset.invuln", 8'(invuln),    8'd0);
    chk("reset.over",   8'(game_over), 8'd0);
    @(negedge clk); reset = 1'b1;

    frame(7, 0);    tick("seven_out", 1'b0);
    frame(8, 0);    tick("eight_out_crash", 1'b0);
    frame(300, 0);  tick("grace_300_out", 1'b0);
    grace_ticks(58);
    chk("grace.still_invuln", 8'(invuln), 8'd1);
    tick("grace_end", 1'b0);

    frame(300, 0);  peek_bank("bank_saturate", 255);
    tick("sat_crash", 1'b0);
    grace_ticks(60);

    for (int i = 0; i < 10; i++) pix(1'b1, 1'b1);
    tick("crash_over_foam", 1'b0);
    frame(20, 0);   tick("over_ignored", 1'b0);
    tick("over_ignored2", 1'b0);
    tick("restart", 1'b1);

    frame(8, 0);    tick("restart_beats_update", 1'b1);
    frame(0, 4);    tick("four_foam", 1'b0);
    frame(0, 3);    tick("three_foam", 1'b0);

    // player_on high only while river_on (previous pixel) is low
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    peek_bank("alignment", 0);
    tick("alignment_tick", 1'b0);

    frame(8, 0);    tick("crash_before_reset", 1'b0);
    frame(5, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_reset.lives",  8'(lives),  8'd3);
    chk("async_reset.invuln", 8'(invuln), 8'd0);
    m_state = 0; m_lives = 3; m_grace = 0; m_bank = 0; m_foam = 0;
    @(negedge clk); reset = 1'b1;
    frame(5, 0);
    #2 reset = 1'b0;
    m_bank = 0; m_foam = 0;
    @(negedge clk); reset = 1'b1;
    frame(3, 0);    tick("partial_frame_discarded", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
